// File: rtl/geofence_driver.sv
// Self-test initiator for the geofence point-in-hexagon engine: replays stored
// patterns with the engine's receive timing and scores its is_inside results.
module geofence_driver #(
    parameter int NUM_PAT = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pat_we,
    input  logic [AW+2:0] pat_addr,
    input  logic [19:0]   pat_wdata,
    input  logic          start,
    input  logic [AW:0]   num_pat,
    output logic          dut_rst,
    output logic [9:0]    X,
    output logic [9:0]    Y,
    input  logic          valid,
    input  logic          is_inside,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   pass_cnt,
    output logic [AW:0]   fail_cnt,
    output logic [AW:0]   first_fail,
    output logic          timeout_err
);
    localparam int          CW        = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] NUM_PAT_C = (AW+1)'(NUM_PAT);
    localparam logic [AW:0] NO_FAIL   = {(AW+1){1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pat_q, pat_d;
    logic [2:0]      slot_q, slot_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW:0]     num_q, num_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic            dut_rst_q, dut_rst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [AW:0]     pass_q, pass_d;
    logic [AW:0]     fail_q, fail_d;
    logic [AW:0]     ff_q, ff_d;
    logic            tmo_q, tmo_d;

    logic [19:0]     mem_q [NUM_PAT*8];
    logic [AW+2:0]   rd_addr_s;
    logic [19:0]     rd_data_s;
    logic            exp_s;
    logic [AW:0]     num_clamp_s;
    logic            last_s;

    // Pattern store; only loaded while idle so a run always sees a stable image
    always_ff @(posedge clk) begin
        if (pat_we && (state_q == S_IDLE)) begin
            mem_q[pat_addr] <= pat_wdata;
        end
    end

    // Read address: the first object when starting, the next object while
    // waiting (it must be on X/Y at the edge valid is sampled), else the slot
    always_comb begin
        case (state_q)
            S_IDLE:  rd_addr_s = {{AW{1'b0}}, 3'd0};
            S_WAIT:  rd_addr_s = {pat_q + AW'(1), 3'd0};
            default: rd_addr_s = {pat_q, slot_q};
        endcase
    end

    assign rd_data_s   = mem_q[rd_addr_s];
    assign exp_s       = mem_q[{pat_q, 3'd7}][0];
    assign num_clamp_s = (num_pat > NUM_PAT_C) ? NUM_PAT_C : num_pat;
    assign last_s      = ({1'b0, pat_q} == (num_q - (AW+1)'(1)));

    // Next-state and output logic of the run sequencer
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        x_d       = x_q;
        y_d       = y_q;
        dut_rst_d = dut_rst_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        fail_d    = fail_q;
        ff_d      = ff_q;
        tmo_d     = tmo_q;
        case (state_q)
            S_IDLE: begin
                dut_rst_d = 1'b1;
                busy_d    = 1'b0;
                if (start) begin
                    pass_d = {(AW+1){1'b0}};
                    fail_d = {(AW+1){1'b0}};
                    ff_d   = NO_FAIL;
                    tmo_d  = 1'b0;
                    if (num_clamp_s == {(AW+1){1'b0}}) begin
                        done_d = 1'b1;
                    end else begin
                        num_d     = num_clamp_s;
                        pat_d     = {AW{1'b0}};
                        x_d       = rd_data_s[19:10];
                        y_d       = rd_data_s[9:0];
                        dut_rst_d = 1'b0;
                        busy_d    = 1'b1;
                        slot_d    = 3'd1;
                        state_d   = S_SEND;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                x_d    = rd_data_s[19:10];
                y_d    = rd_data_s[9:0];
                slot_d = slot_q + 3'd1;
                if (slot_q == 3'd6) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_WAIT;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_WAIT: begin
                if (valid) begin
                    if (is_inside == exp_s) begin
                        pass_d = pass_q + (AW+1)'(1);
                    end else begin
                        fail_d = fail_q + (AW+1)'(1);
                        if (ff_q == NO_FAIL) begin
                            ff_d = {1'b0, pat_q};
                        end else begin
                            ff_d = ff_q;
                        end
                    end
                    if (last_s) begin
                        state_d = S_FIN;
                    end else begin
                        pat_d   = pat_q + AW'(1);
                        x_d     = rd_data_s[19:10];
                        y_d     = rd_data_s[9:0];
                        slot_d  = 3'd1;
                        state_d = S_SEND;
                    end
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    fail_d  = fail_q + (AW+1)'(1);
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIN: begin
                dut_rst_d = 1'b1;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs; the engine reset follows reset at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pat_q     <= {AW{1'b0}};
            slot_q    <= 3'd0;
            cnt_q     <= {CW{1'b0}};
            num_q     <= {(AW+1){1'b0}};
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            dut_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= {(AW+1){1'b0}};
            fail_q    <= {(AW+1){1'b0}};
            ff_q      <= NO_FAIL;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dut_rst_q <= dut_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            ff_q      <= ff_d;
            tmo_q     <= tmo_d;
        end
    end

    assign dut_rst     = dut_rst_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass_cnt    = pass_q;
    assign fail_cnt    = fail_q;
    assign first_fail  = ff_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_geofence_driver.sv
// Scoreboard bench for geofence_driver: a behavioural engine checks the points it
// samples and answers from a queue; a done monitor checks the run summary.
module tb_geofence_driver;
    localparam int AW      = 4;
    localparam int ENG_LAT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          pat_we;
    logic [AW+2:0] pat_addr;
    logic [19:0]   pat_wdata;
    logic          start;
    logic [AW:0]   num_pat;
    logic          dut_rst;
    logic [9:0]    X, Y;
    logic          valid = 1'b0;
    logic          is_inside = 1'b0;
    logic          busy, done;
    logic [AW:0]   pass_cnt, fail_cnt, first_fail;
    logic          timeout_err;

    geofence_driver #(.NUM_PAT(16), .AW(AW), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .pat_we(pat_we), .pat_addr(pat_addr),
        .pat_wdata(pat_wdata), .start(start), .num_pat(num_pat),
        .dut_rst(dut_rst), .X(X), .Y(Y), .valid(valid), .is_inside(is_inside),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail(first_fail), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] p;
        logic [4:0] f;
        logic [4:0] ff;
        logic       t;
    } sum_t;

    int          n_pass = 0;
    int          n_total = 0;
    logic [19:0] tb_mem [0:127];
    logic [19:0] pt_q [$];
    logic        ans_q [$];
    sum_t        sum_q [$];
    bit          eng_novalid = 1'b0;
    int          eng_ph = 0;
    int          eng_lat = 0;
    logic [19:0] last_pt = 20'd0;
    bit          done_prev = 1'b0;
    int          fx [6] = '{600, 550, 450, 400, 450, 550};
    int          fy [6] = '{500, 587, 587, 500, 413, 413};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    // Behavioural engine: object on the first edge after reset release, six fence
    // points, then a one-cycle valid, one ignored edge, then the next object
    always @(posedge clk) begin
        logic [19:0] pt_s;
        logic        v_n;
        logic        a_n;
        pt_s = {X, Y};
        v_n  = 1'b0;
        a_n  = 1'b0;
        if (dut_rst) begin
            eng_ph  = 0;
            eng_lat = 0;
        end else if (eng_ph <= 6) begin
            if (pt_q.size() != 0) chk("eng_point", pt_s, pt_q.pop_front());
            last_pt = pt_s;
            eng_ph++;
            eng_lat = 0;
        end else if (eng_ph == 7) begin
            chk("hold_last_fence", pt_s, last_pt);
            eng_lat++;
            if (!eng_novalid && eng_lat == ENG_LAT) begin
                v_n = 1'b1;
                if (ans_q.size() != 0) a_n = ans_q.pop_front();
                eng_ph = 8;
            end
        end else begin
            eng_ph = 0;
        end
        #1;
        valid     = v_n;
        is_inside = a_n;
    end

    // Done monitor: pops the expected summary whenever the driver reports done
    always @(negedge clk) begin
        sum_t s;
        if (done_prev) chk("done_one_cycle", done, 1'b0);
        done_prev = done;
        if (done) begin
            if (sum_q.size() == 0) begin
                chk("unexpected_done", sum_q.size(), 1);
            end else begin
                s = sum_q.pop_front();
                chk("pass_cnt", pass_cnt, s.p);
                chk("fail_cnt", fail_cnt, s.f);
                chk("first_fail", first_fail, s.ff);
                chk("timeout_err", timeout_err, s.t);
                chk("done_dut_rst", dut_rst, 1'b1);
                chk("done_busy", busy, 1'b0);
            end
        end
    end

    task automatic wr_raw(input int idx, input int slot, input logic [19:0] d);
        @(negedge clk);
        pat_we    = 1'b1;
        pat_addr  = 7'(idx * 8 + slot);
        pat_wdata = d;
        @(negedge clk);
        pat_we    = 1'b0;
    endtask

    task automatic wr(input int idx, input int slot, input logic [19:0] d);
        wr_raw(idx, slot, d);
        tb_mem[idx * 8 + slot] = d;
    endtask

    task automatic load_pat(input int idx, input int ox, input int oy, input logic e);
        wr(idx, 0, {10'(ox), 10'(oy)});
        for (int k = 0; k < 6; k++) wr(idx, k + 1, {10'(fx[k]), 10'(fy[k])});
        wr(idx, 7, {19'd0, e});
    endtask

    task automatic queue_run(input int n, input logic [15:0] ans, input bit with_ans,
                             input int p, input int f, input int ff, input bit t);
        int   m;
        sum_t s;
        m = (n > 16) ? 16 : n;
        for (int i = 0; i < m; i++) begin
            for (int k = 0; k < 7; k++) pt_q.push_back(tb_mem[i * 8 + k]);
            if (with_ans) ans_q.push_back(ans[i]);
        end
        s.p  = 5'(p);
        s.f  = 5'(f);
        s.ff = 5'(ff);
        s.t  = t;
        sum_q.push_back(s);
    endtask

    task automatic issue_start(input int n);
        @(negedge clk);
        start   = 1'b1;
        num_pat = 5'(n);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit got;
        got = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("run_done", got, 1'b1);
        chk("points_left", pt_q.size(), 0);
        chk("answers_left", ans_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still active at %0t, limit 1000000", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; pat_we = 1'b0; pat_addr = 7'd0; pat_wdata = 20'd0;
        start = 1'b0; num_pat = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_dut_rst", dut_rst, 1'b1);
        chk("rst_xy", {X, Y}, 20'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass_cnt, 5'd0);
        chk("rst_fail", fail_cnt, 5'd0);
        chk("rst_first_fail", first_fail, 5'h1f);
        chk("rst_timeout", timeout_err, 1'b0);
        reset = 1'b0;

        load_pat(0, 500, 500, 1'b1);
        load_pat(1, 700, 700, 1'b0);

        // single matching pattern
        queue_run(1, 16'h0001, 1'b1, 1, 0, 31, 1'b0);
        issue_start(1);
        wait_done(200);

        // back-to-back patterns
        queue_run(2, 16'h0001, 1'b1, 2, 0, 31, 1'b0);
        issue_start(2);
        wait_done(200);

        // expected 0 but the engine says 1
        wr(0, 7, 20'd0);
        queue_run(1, 16'h0001, 1'b1, 0, 1, 0, 1'b0);
        issue_start(1);
        wait_done(200);
        wr(0, 7, 20'd1);

        // engine never answers
        eng_novalid = 1'b1;
        queue_run(1, 16'h0000, 1'b0, 0, 1, 31, 1'b1);
        issue_start(1);
        wait_done(600);
        eng_novalid = 1'b0;

        // reset while the third fence point is on X/Y
        issue_start(1);
        repeat (3) @(posedge clk);
        #2;
        chk("slot3_loaded", {X, Y}, tb_mem[3]);
        reset = 1'b1;
        #1;
        chk("mid_rst_dut_rst", dut_rst, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_xy", {X, Y}, 20'd0);
        @(negedge clk);
        reset = 1'b0;
        queue_run(1, 16'h0001, 1'b1, 1, 0, 31, 1'b0);
        issue_start(1);
        wait_done(200);

        // writes and start while busy are ignored
        queue_run(2, 16'h0001, 1'b1, 2, 0, 31, 1'b0);
        issue_start(2);
        chk("busy_in_run", busy, 1'b1);
        start = 1'b1; num_pat = 5'd1;
        @(negedge clk);
        start = 1'b0;
        wr_raw(0, 1, 20'd0);
        wr_raw(1, 7, 20'd1);
        wait_done(200);
        queue_run(1, 16'h0001, 1'b1, 1, 0, 31, 1'b0);
        issue_start(1);
        wait_done(200);

        // empty run
        queue_run(0, 16'h0000, 1'b1, 0, 0, 31, 1'b0);
        issue_start(0);
        wait_done(10);

        // num_pat above NUM_PAT clamps to 16; pattern 5 mismatches
        for (int i = 0; i < 16; i++) load_pat(i, i * 30 + 10, i * 20 + 5, 1'(i % 2));
        queue_run(20, 16'hAAAA ^ 16'h0020, 1'b1, 15, 1, 5, 1'b0);
        issue_start(20);
        wait_done(2000);

        repeat (3) @(negedge clk);
        chk("summaries_left", sum_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
